// File: rtl/kyber_keygen_sched.sv
// Baby Kyber key-generation sequencer: one shared polynomial multiplier runs the
// four A*s products in turn, accumulates them per row, adds e and reduces mod Q.
module kyber_keygen_sched #(
  parameter int Q       = 17,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0][3:0][W-1:0]   A,
  input  logic [1:0][3:0][W-1:0]   secret_key,
  input  logic [1:0][3:0][W-1:0]   e,
  output logic                     mul_en,
  output logic [3:0][W-1:0]        mul_poly_a,
  output logic [3:0][W-1:0]        mul_poly_b,
  output logic [1:0]               mul_idx,
  input  logic                     mul_valid,
  input  logic [3:0][W-1:0]        mul_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0][3:0][W-1:0]   result
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [W-1:0] QW = W'(Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINAL,
    S_DONE
  } state_t;

  state_t                   state;
  logic [3:0][3:0][W-1:0]   a_reg;
  logic [1:0][3:0][W-1:0]   s_reg;
  logic [1:0][3:0][W-1:0]   e_reg;
  logic [1:0][3:0][W-1:0]   acc;
  logic [1:0]               p;
  logic [CW-1:0]            wait_cnt;
  logic [1:0]               p_next;

  assign p_next = p + 2'd1;

  // Wrapping add of the error term, then signed remainder folded into [0, Q-1].
  function automatic logic [W-1:0] mod_q(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] x;
    logic signed [W-1:0] m;
    x = $signed(a + b);
    m = x % QW;
    if (m < 0) m = m + QW;
    return m;
  endfunction

  // NOTE: every register here is state, so all updates are non-blocking; the
  // operand and accumulator arrays are plain flops and are cleared by reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      s_reg      <= '0;
      e_reg      <= '0;
      acc        <= '0;
      p          <= '0;
      wait_cnt   <= '0;
      mul_en     <= 1'b0;
      mul_poly_a <= '0;
      mul_poly_b <= '0;
      mul_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
    end else begin
      mul_en <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_reg      <= A;
            s_reg      <= secret_key;
            e_reg      <= e;
            acc        <= '0;
            err        <= 1'b0;
            p          <= '0;
            mul_idx    <= '0;
            mul_poly_a <= A[0];
            mul_poly_b <= secret_key[0];
            mul_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_valid) begin
            for (int c = 0; c < 4; c++) begin
              acc[p[1]][c] <= acc[p[1]][c] + mul_out[c];
            end
            if (p == 2'd3) begin
              state <= S_FINAL;
            end else begin
              p          <= p_next;
              mul_idx    <= p_next;
              mul_poly_a <= a_reg[p_next];
              mul_poly_b <= s_reg[p_next[0]];
              mul_en     <= 1'b1;
              state      <= S_ISSUE;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Abort leaves result untouched; err stays up until the next start.
            if (wait_cnt == CW'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_FINAL: begin
          for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
              result[r][c] <= mod_q(acc[r][c], e_reg[r][c]);
            end
          end
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_keygen_sched.sv
// Directed bench for kyber_keygen_sched: behavioural multiplier with programmable
// latency, scoreboard of reference keys, and cycle-exact timing checks.
module tb_kyber_keygen_sched;

  localparam int W = 32;

  typedef logic [3:0][3:0][W-1:0] mat_t;
  typedef logic [1:0][3:0][W-1:0] vec_t;
  typedef logic [3:0][W-1:0]      poly_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  start;
  mat_t  A;
  vec_t  sk;
  vec_t  e;
  logic  mul_en;
  poly_t mul_poly_a;
  poly_t mul_poly_b;
  logic  [1:0] mul_idx;
  logic  mul_valid = 1'b0;
  poly_t mul_out = '0;
  logic  busy;
  logic  done;
  logic  err;
  vec_t  result;

  int checks = 0;
  int errors = 0;

  int model_lat    = 1;
  bit model_silent = 1'b0;
  int rem          = 0;

  vec_t exp_q[$];
  vec_t last_exp;

  kyber_keygen_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .secret_key (sk),
    .e          (e),
    .mul_en     (mul_en),
    .mul_poly_a (mul_poly_a),
    .mul_poly_b (mul_poly_b),
    .mul_idx    (mul_idx),
    .mul_valid  (mul_valid),
    .mul_out    (mul_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result)
  );

  always #5 clk = ~clk;

  // Pointwise multiplier: result strobes model_lat cycles after the request.
  always @(posedge clk) begin
    if (mul_en && !model_silent) begin
      for (int c = 0; c < 4; c++) mul_out[c] <= mul_poly_a[c] * mul_poly_b[c];
      rem       <= model_lat - 1;
      mul_valid <= (model_lat == 1);
    end else if (rem > 0) begin
      rem       <= rem - 1;
      mul_valid <= (rem == 1);
    end else begin
      mul_valid <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t ref_key(input mat_t a, input vec_t s, input vec_t ee);
    vec_t res;
    int acc, x, m;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        for (int p = 2 * r; p < 2 * r + 2; p++) acc += int'(a[p][c]) * int'(s[p % 2][c]);
        x = acc + int'(ee[r][c]);
        m = x % 17;
        if (m < 0) m += 17;
        res[r][c] = m;
      end
    end
    return res;
  endfunction

  function automatic poly_t fill(input int v);
    poly_t pl;
    for (int c = 0; c < 4; c++) pl[c] = v;
    return pl;
  endfunction

  function automatic vec_t fill_vec(input int r0, input int r1);
    vec_t v;
    v[0] = fill(r0);
    v[1] = fill(r1);
    return v;
  endfunction

  // One key generation: start in cycle 0, then watch every cycle until busy falls.
  task automatic run(input int lat, input bit silent, input int glitch_cyc, input bit scramble,
                     output int done_first, output int done_cnt, output int busy_first,
                     output int busy_last, output int en_cnt, output int err_first,
                     output bit finished);
    mat_t a_sv;
    vec_t s_sv;
    logic [255:0] snap;
    model_lat    = lat;
    model_silent = silent;
    done_first = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
    en_cnt = 0; err_first = -1; finished = 1'b0; snap = '0;
    @(negedge clk);
    start = 1'b1;
    a_sv = A;
    s_sv = sk;
    if (!silent) exp_q.push_back(ref_key(A, sk, e));
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = (k == glitch_cyc);
      if (busy) begin
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (err && err_first < 0) err_first = k;
      if (done) begin
        done_cnt++;
        if (done_first < 0) done_first = k;
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else check("result_vs_model", result, exp_q.pop_front());
      end
      if (mul_en) begin
        check("mul_idx", mul_idx, en_cnt % 4);
        check("mul_poly_a", mul_poly_a, a_sv[en_cnt % 4]);
        check("mul_poly_b", mul_poly_b, s_sv[en_cnt % 2]);
        snap = {mul_poly_a, mul_poly_b};
        en_cnt++;
      end else if (busy && en_cnt > 0) begin
        check("operands_stable", {mul_poly_a, mul_poly_b}, snap);
      end
      if (scramble) begin
        for (int p = 0; p < 4; p++) for (int c = 0; c < 4; c++) A[p][c] = $urandom;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) begin
          sk[r][c] = $urandom;
          e[r][c]  = $urandom;
        end
      end
      if (!busy && k > glitch_cyc) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    model_silent = 1'b0;
  endtask

  int  d_first, d_cnt, b_first, b_last, n_en, e_first;
  bit  fin;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A = '0; sk = '0; e = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", {mul_en, busy, done, err}, 4'b0000);
    check("reset_idx", mul_idx, 2'd0);
    check("reset_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Uniform operands, L = 1: every coefficient is 2*3 + 2*3 + 1 = 13.
    for (int p = 0; p < 4; p++) A[p] = fill(2);
    sk = fill_vec(3, 3);
    e  = fill_vec(1, 1);
    run(1, 1'b0, 0, 1'b0, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("t1_finished", fin, 1'b1);
    check("t1_result_const", result, fill_vec(13, 13));
    check("t1_done_cycle", d_first, 10);
    check("t1_done_count", d_cnt, 1);
    check("t1_busy_first", b_first, 1);
    check("t1_busy_last", b_last, 10);
    check("t1_mul_en_count", n_en, 4);
    check("t1_err", e_first, -1);

    // Negative product wraps and reduces to 12.
    A = '0;
    A[0] = fill(-5);
    sk = fill_vec(1, 1);
    e  = '0;
    run(1, 1'b0, 0, 1'b0, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("neg_finished", fin, 1'b1);
    check("neg_result", result, fill_vec(12, 0));
    e[1] = fill(-20);
    run(1, 1'b0, 0, 1'b0, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("neg_e_result", result, fill_vec(12, 14));
    last_exp = fill_vec(12, 14);

    // Multiplier never answers: abort after TIMEOUT wait cycles.
    for (int p = 0; p < 4; p++) A[p] = fill(7);
    run(1, 1'b1, 0, 1'b0, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("to_finished", fin, 1'b1);
    check("to_mul_en_count", n_en, 1);
    check("to_err_cycle", e_first, 66);
    check("to_busy_last", b_last, 65);
    check("to_no_done", d_cnt, 0);
    check("to_result_kept", result, last_exp);
    check("to_err_sticky", err, 1'b1);

    // Recovery run clears err at start.
    for (int p = 0; p < 4; p++) A[p] = fill(p + 1);
    sk = fill_vec(-4, 9);
    e  = fill_vec(100, -3);
    run(1, 1'b0, 0, 1'b0, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("rec_err_cleared", e_first, -1);
    check("rec_done_cycle", d_first, 10);

    // L = 5 with a start pulse injected mid-run, random full-width operands.
    for (int p = 0; p < 4; p++) for (int c = 0; c < 4; c++) A[p][c] = $urandom;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++) begin
      sk[r][c] = $urandom;
      e[r][c]  = $urandom;
    end
    run(5, 1'b0, 7, 1'b0, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("l5_finished", fin, 1'b1);
    check("l5_done_cycle", d_first, 26);
    check("l5_done_count", d_cnt, 1);
    check("l5_busy_last", b_last, 26);
    check("l5_mul_en_count", n_en, 4);

    // Reset in cycle 4 of an L = 5 run; the response due in cycle 6 must be dropped.
    model_lat = 5;
    for (int p = 0; p < 4; p++) A[p] = fill(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_ctrl", {mul_en, busy, done, err}, 4'b0000);
    check("rst_idx", mul_idx, 2'd0);
    check("rst_result", result, '0);
    check("rst_operands", {mul_poly_a, mul_poly_b}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      @(negedge clk);
      check("rst_late_valid_ignored", {busy, done, result}, '0);
    end

    // Inputs churn every cycle while busy; only the start-time operands count.
    for (int p = 0; p < 4; p++) A[p] = fill(5 - 3 * p);
    sk = fill_vec(6, -2);
    e  = fill_vec(-1, 40);
    run(1, 1'b0, 0, 1'b1, d_first, d_cnt, b_first, b_last, n_en, e_first, fin);
    check("scr_finished", fin, 1'b1);
    check("scr_done_cycle", d_first, 10);
    check("scr_scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
